// File: rtl/pe_pkg.sv
// Shared constants, FSM encoding and saturation helpers for the streaming MAC PE.
package pe_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned AW_DEF     = 32;
  localparam int unsigned OW_DEF     = 8;
  localparam int unsigned SHW_DEF    = 5;
  localparam int unsigned FRAC_DEF   = 12;
  localparam int          THRESH_DEF = 64;

  // Working width for the generic saturation helpers; covers AW up to 63.
  localparam int unsigned SATW = 64;

  localparam logic [1:0] MODE_RELU = 2'b00;
  localparam logic [1:0] MODE_SIG  = 2'b01;
  localparam logic [1:0] MODE_RAW  = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_ACT  = 2'd2;
  localparam state_t ST_OUT  = 2'd3;

  // Clamp x to a w-bit range: two's complement when is_signed, else [0, 2^w-1].
  function automatic logic signed [SATW-1:0] sat_ow(input logic signed [SATW-1:0] x,
                                                    input int unsigned w,
                                                    input logic is_signed);
    logic signed [SATW-1:0] one;
    logic signed [SATW-1:0] hi;
    logic signed [SATW-1:0] lo;
    one = SATW'(1);
    if (is_signed) begin
      hi = (one <<< (w - 1)) - one;
      lo = -hi - one;
    end else begin
      hi = (one <<< w) - one;
      lo = '0;
    end
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic signed [SATW-1:0] sat_aw(input logic signed [SATW-1:0] x,
                                                    input int unsigned w);
    return sat_ow(x, w, 1'b1);
  endfunction

endpackage

// File: rtl/pe_stream_mac_if.sv
// Beat-in / result-out handshake bundle of the streaming MAC PE.
interface pe_stream_mac_if #(
  parameter int unsigned DW  = pe_pkg::DW_DEF,
  parameter int unsigned OW  = pe_pkg::OW_DEF,
  parameter int unsigned SHW = pe_pkg::SHW_DEF
);

  logic                  i_valid;
  logic                  o_ready;
  logic signed [DW-1:0]  i_data;
  logic signed [DW-1:0]  i_weight;
  logic                  i_last;
  logic [1:0]            i_mode;
  logic [SHW-1:0]        i_shift;
  logic                  o_valid;
  logic                  i_ready;
  logic [OW-1:0]         o_data;
  logic                  o_decision;
  logic                  o_ovf;

  modport slave (
    input  i_valid, i_data, i_weight, i_last, i_mode, i_shift, i_ready,
    output o_ready, o_valid, o_data, o_decision, o_ovf
  );

  modport master (
    output i_valid, i_data, i_weight, i_last, i_mode, i_shift, i_ready,
    input  o_ready, o_valid, o_data, o_decision, o_ovf
  );

endinterface

// File: rtl/pe_quant.sv
// Combinational activation, shift-quantize and output saturation for one accumulator value.
// PE_QROUND_EN selects round-half-up quantization instead of truncation.
module pe_quant
  import pe_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned SHW    = SHW_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int          THRESH = THRESH_DEF
) (
  input  logic signed [AW-1:0] acc,
  input  logic [1:0]           mode,
  input  logic [SHW-1:0]       shift,
  output logic [OW-1:0]        data_c,
  output logic                 decision_c
);

  localparam int unsigned XW = AW + 1;
  localparam logic signed [XW-1:0] ONE  = XW'(1) << FRAC;
  localparam logic signed [XW-1:0] HALF = ONE >>> 1;

  logic                   is_raw;
  logic signed [XW-1:0]   acc_x;
  logic signed [XW-1:0]   sig_x;
  logic signed [XW-1:0]   sig_c;
  logic signed [XW-1:0]   act_x;
  logic signed [XW-1:0]   q_x;
  logic signed [SATW-1:0] sat_x;

  always_comb begin
    is_raw = (mode != MODE_RELU) && (mode != MODE_SIG);
    acc_x  = XW'(acc);
    sig_x  = (acc_x >>> 2) + HALF;
    sig_c  = sig_x;
    if (sig_x[XW-1]) begin
      sig_c = '0;
    end else if (sig_x > ONE) begin
      sig_c = ONE;
    end

    case (mode)
      MODE_RELU: act_x = acc_x[XW-1] ? '0 : acc_x;
      MODE_SIG:  act_x = sig_c;
      default:   act_x = acc_x;
    endcase

`ifdef PE_QROUND_EN
    // Beyond AW the half-LSB bias dominates any in-range value, so the rounded result is 0.
    if (shift == '0) begin
      q_x = act_x;
    end else if (32'(shift) > AW) begin
      q_x = '0;
    end else begin
      q_x = (act_x + (XW'(1) << (shift - SHW'(1)))) >>> shift;
    end
`else
    q_x = act_x >>> shift;
`endif

    sat_x      = sat_ow(SATW'(q_x), OW, is_raw);
    data_c     = OW'(sat_x);
    // sat_x already carries the signed or unsigned interpretation of data_c.
    decision_c = (sat_x >= SATW'(THRESH));
  end

endmodule

// File: rtl/pe_stream_mac.sv
// Streaming signed MAC PE: accumulates a beat vector, applies activation + quantization, emits one result.
// Build option PE_QROUND_EN: round-half-up quantization (see pe_quant).
module pe_stream_mac
  import pe_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned SHW    = SHW_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int          THRESH = THRESH_DEF
) (
  input logic             i_clk,
  input logic             i_rst,
  pe_stream_mac_if.slave  bus
);

  localparam int unsigned PW = 2 * DW;

  state_t                 state, state_d;
  logic signed [AW-1:0]   acc, acc_d;
  logic                   ovf, ovf_d;
  logic [1:0]             mode_q, mode_d;
  logic [SHW-1:0]         shift_q, shift_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [OW-1:0]          data_q, data_d;
  logic                   dec_q, dec_d;
  logic                   ovf_out_q, ovf_out_d;

  logic                   beat;
  logic signed [PW-1:0]   prod;
  logic signed [SATW-1:0] sum_x;
  logic signed [SATW-1:0] sum_sat;
  logic [OW-1:0]          q_data_c;
  logic                   q_dec_c;

  pe_quant #(
    .AW     (AW),
    .OW     (OW),
    .SHW    (SHW),
    .FRAC   (FRAC),
    .THRESH (THRESH)
  ) u_quant (
    .acc        (acc),
    .mode       (mode_q),
    .shift      (shift_q),
    .data_c     (q_data_c),
    .decision_c (q_dec_c)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    ovf_d     = ovf;
    mode_d    = mode_q;
    shift_d   = shift_q;
    valid_d   = valid_q;
    data_d    = data_q;
    dec_d     = dec_q;
    ovf_out_d = ovf_out_q;

    beat    = bus.i_valid && ready_q;
    prod    = PW'(bus.i_data) * PW'(bus.i_weight);
    sum_x   = SATW'(acc) + SATW'(prod);
    sum_sat = sat_aw(sum_x, AW);

    case (state)
      ST_IDLE: begin
        if (beat) begin
          acc_d   = AW'(prod);
          mode_d  = bus.i_mode;
          shift_d = bus.i_shift;
          ovf_d   = 1'b0;
          state_d = bus.i_last ? ST_ACT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat) begin
          acc_d = AW'(sum_sat);
          ovf_d = ovf || (sum_sat != sum_x);
          if (bus.i_last) state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        data_d    = q_data_c;
        dec_d     = q_dec_c;
        ovf_out_d = ovf;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        // First OUT cycle raises o_valid; the result leaves on the following handshake.
        if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_ACC);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      mode_q    <= MODE_RELU;
      shift_q   <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      dec_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      ovf       <= ovf_d;
      mode_q    <= mode_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      dec_q     <= dec_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_decision = dec_q;
  assign bus.o_ovf      = ovf_out_q;

endmodule

// File: tb/tb_pe_stream_mac.sv
// Directed bench for pe_stream_mac: table of vectors plus backpressure, overflow, large-shift and reset sequences.
module tb_pe_stream_mac;
  import pe_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned OW  = 8;
  localparam int unsigned SHW = 5;

`ifdef PE_QROUND_EN
  localparam logic [7:0] EXP_RND6  = 8'h02;
  localparam logic [7:0] EXP_NEG3  = 8'hFF;
  localparam logic [7:0] EXP_BIGSH = 8'h00;
`else
  localparam logic [7:0] EXP_RND6  = 8'h01;
  localparam logic [7:0] EXP_NEG3  = 8'hFE;
  localparam logic [7:0] EXP_BIGSH = 8'hFF;
`endif

  typedef struct {
    int         n;
    int         d0, w0, d1, w1, d2, w2;
    logic [1:0] mode;
    int         shift;
    logic [7:0] ed;
    bit         edec;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid, last, rdy;
  logic signed [DW-1:0] d, w;
  logic [1:0]           mode;
  logic [SHW-1:0]       shift;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_stream_mac_if #(.DW(DW), .OW(OW), .SHW(SHW)) bus_a ();
  pe_stream_mac_if #(.DW(DW), .OW(OW), .SHW(SHW)) bus_b ();

  assign bus_a.i_valid  = valid;
  assign bus_a.i_data   = d;
  assign bus_a.i_weight = w;
  assign bus_a.i_last   = last;
  assign bus_a.i_mode   = mode;
  assign bus_a.i_shift  = shift;
  assign bus_a.i_ready  = rdy;
  assign bus_b.i_valid  = valid;
  assign bus_b.i_data   = d;
  assign bus_b.i_weight = w;
  assign bus_b.i_last   = last;
  assign bus_b.i_mode   = mode;
  assign bus_b.i_shift  = shift;
  assign bus_b.i_ready  = rdy;

  pe_stream_mac #(.DW(DW), .AW(32), .OW(OW), .SHW(SHW), .FRAC(12), .THRESH(64)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  // Narrow accumulator instance for saturation and shift >= AW cases.
  pe_stream_mac #(.DW(DW), .AW(16), .OW(OW), .SHW(SHW), .FRAC(12), .THRESH(64)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int bd, input int bw, input bit bl, input logic [1:0] bm, input int bs);
    int t;
    t     = 0;
    valid = 1'b1;
    d     = DW'(bd);
    w     = DW'(bw);
    last  = bl;
    mode  = bm;
    shift = SHW'(bs);
    while (!bus_a.o_ready && t < 20) begin
      tick();
      t++;
    end
    check("beat_ready", 32'(bus_a.o_ready), 32'd1);
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_result();
    tick();
    check("lat_early", 32'(bus_a.o_valid), 32'd0);
    tick();
    check("lat_valid", 32'(bus_a.o_valid), 32'd1);
  endtask

  task automatic check_out(input string tag, input bit sel_b, input logic [7:0] ed,
                           input bit edec, input bit eovf);
    logic [7:0] ad;
    logic       adec, aovf;
    ad   = sel_b ? bus_b.o_data     : bus_a.o_data;
    adec = sel_b ? bus_b.o_decision : bus_a.o_decision;
    aovf = sel_b ? bus_b.o_ovf      : bus_a.o_ovf;
    check({tag, "_data"}, 32'(ad), 32'(ed));
    check({tag, "_dec"},  32'(adec), 32'(edec));
    check({tag, "_ovf"},  32'(aovf), 32'(eovf));
  endtask

  task automatic transfer();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("xfer_valid", 32'(bus_a.o_valid), 32'd0);
    check("xfer_ready", 32'(bus_a.o_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt[13];
    int   bd[3];
    int   bw[3];

    vt[0]  = '{3,    3,   4,  -2,   5, 7, 1, MODE_RELU, 0, 8'h09, 1'b0};
    vt[1]  = '{2, -100, 100, -50,  20, 0, 0, MODE_RAW,  2, 8'h80, 1'b0};
    vt[2]  = '{1,   64,  64,   0,   0, 0, 0, MODE_SIG,  5, 8'h60, 1'b1};
    vt[3]  = '{1,   -5,   5,   0,   0, 0, 0, MODE_RELU, 0, 8'h00, 1'b0};
    vt[4]  = '{1,  127, 127,   0,   0, 0, 0, MODE_SIG,  4, 8'hFF, 1'b1};
    vt[5]  = '{1, -127, 127,   0,   0, 0, 0, MODE_SIG,  0, 8'h00, 1'b0};
    vt[6]  = '{1,   10,  10,   0,   0, 0, 0, MODE_RAW,  0, 8'h64, 1'b1};
    vt[7]  = '{1,   50,  50,   0,   0, 0, 0, MODE_RAW,  0, 8'h7F, 1'b1};
    vt[8]  = '{1,    6,   1,   0,   0, 0, 0, MODE_RAW,  2, EXP_RND6, 1'b0};
    vt[9]  = '{1,   -3,   1,   0,   0, 0, 0, 2'b11,     1, EXP_NEG3, 1'b0};
    vt[10] = '{1,    8,   8,   0,   0, 0, 0, MODE_RELU, 0, 8'h40, 1'b1};
    vt[11] = '{1,    9,   7,   0,   0, 0, 0, MODE_RELU, 0, 8'h3F, 1'b0};
    vt[12] = '{1,   -8,   8,   0,   0, 0, 0, MODE_RAW,  0, 8'hC0, 1'b0};

    rst = 1'b0; valid = 1'b0; last = 1'b0; rdy = 1'b0;
    d = '0; w = '0; mode = MODE_RELU; shift = '0;
    tick();
    tick();
    check("rst_valid", 32'(bus_a.o_valid), 32'd0);
    check("rst_ready", 32'(bus_a.o_ready), 32'd1);
    check_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    // Table: later beats carry inverted mode/shift, which must be ignored.
    for (int i = 0; i < 13; i++) begin
      bd = '{vt[i].d0, vt[i].d1, vt[i].d2};
      bw = '{vt[i].w0, vt[i].w1, vt[i].w2};
      for (int b = 0; b < vt[i].n; b++) begin
        offer(bd[b], bw[b], b == vt[i].n - 1,
              (b == 0) ? vt[i].mode : ~vt[i].mode,
              (b == 0) ? vt[i].shift : (vt[i].shift ^ 31));
      end
      wait_result();
      check_out($sformatf("v%0d", i), 1'b0, vt[i].ed, vt[i].edec, 1'b0);
      transfer();
    end

    // Backpressure: result held, offered beat not taken until after transfer.
    offer(2, 3, 1'b1, MODE_RELU, 0);
    wait_result();
    valid = 1'b1; d = 8'sd100; w = 8'sd100; last = 1'b1; mode = MODE_RELU; shift = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", 32'(bus_a.o_valid), 32'd1);
      check("bp_data",  32'(bus_a.o_data), 32'h06);
      check("bp_ready", 32'(bus_a.o_ready), 32'd0);
    end
    transfer();
    tick();
    valid = 1'b0;
    last  = 1'b0;
    wait_result();
    check_out("bp_next", 1'b0, 8'hFF, 1'b1, 1'b0);
    transfer();

    // Overflow: 10 x 127*127 saturates the 16-bit accumulator only.
    for (int b = 0; b < 10; b++) offer(127, 127, b == 9, MODE_RELU, 8);
    wait_result();
    check_out("ovf_b", 1'b1, 8'h7F, 1'b1, 1'b1);
    check_out("ovf_a", 1'b0, 8'hFF, 1'b1, 1'b0);
    transfer();

    // Shift beyond AW=16 on a negative raw value; ovf clears on the new vector.
    offer(-3, 3, 1'b1, MODE_RAW, 20);
    wait_result();
    check_out("bigsh_b", 1'b1, EXP_BIGSH, 1'b0, 1'b0);
    check_out("bigsh_a", 1'b0, EXP_BIGSH, 1'b0, 1'b0);
    transfer();

    // Reset while a result is pending.
    offer(4, 4, 1'b1, MODE_RELU, 0);
    wait_result();
    check("pre_rst_data", 32'(bus_a.o_data), 32'h10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_out_valid", 32'(bus_a.o_valid), 32'd0);
    check("rst_out_ready", 32'(bus_a.o_ready), 32'd1);
    check("rst_out_data",  32'(bus_a.o_data), 32'h00);

    // Reset mid-accumulation must discard the partial sum.
    offer(5, 5, 1'b0, MODE_RELU, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_acc_valid", 32'(bus_a.o_valid), 32'd0);
    check("rst_acc_ready", 32'(bus_a.o_ready), 32'd1);
    offer(2, 2, 1'b1, MODE_RELU, 0);
    wait_result();
    check_out("post_rst", 1'b0, 8'h04, 1'b0, 1'b0);
    transfer();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
